snowflake_ssd_mux: RTL

SNOWFLAKE_SSD_MUX -- requirements
Module: snowflake_ssd_mux

---
 rtl/snowflake_ssd_mux.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/snowflake_ssd_mux.sv
// Multiplexed 7-segment display driver with a small register interface.
// Covers digit scan, 16-step PWM brightness, frame-based blink and registered outputs.
module snowflake_ssd_mux #(
  parameter int NDIGITS        = 2,
  parameter int REFRESH_DIV    = 12000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic               sys_en,
  input  logic               sys_wr_en,
  input  logic [31:0]        sys_addr,
  input  logic [31:0]        sys_wr_data,
  output logic [31:0]        sys_rd_data,
  output logic [6:0]         seg,
  output logic [NDIGITS-1:0] sel
);

  localparam int            PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NDIGITS - 1);

  logic [5:0] word;
  logic       wr_stb, rd_stb, ctrl_wr, blink_wr;

  assign word     = sys_addr[7:2];
  assign wr_stb   = sys_en & sys_wr_en;
  assign rd_stb   = sys_en & ~sys_wr_en;
  assign ctrl_wr  = wr_stb && (word == 6'h00);
  assign blink_wr = wr_stb && (word == 6'h01);

  logic unused_bits;
  assign unused_bits = ^{sys_addr[31:8], sys_addr[1:0], sys_wr_data[31:16]};

  logic          en_q, blink_en_q, blink_phase_q;
  logic [3:0]    bright_q, phase_q;
  logic [15:0]   blink_period_q, frame_q;
  logic [6:0]    digit_q [NDIGITS];
  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [6:0]    seg_q;
  logic [NDIGITS-1:0] sel_q;
  logic [31:0]   rd_data_q;

  logic          en_d, blink_phase_d, frame_done, out_active;
  logic [3:0]    phase_d;
  logic [15:0]   frame_d;
  logic [PW-1:0] presc_d;
  logic [2:0]    idx_d;
  logic [6:0]    seg_pat, seg_d;
  logic [NDIGITS-1:0] sel_d;
  logic [31:0]   rd_mux, rd_data_d;

  // Disabling takes effect in the same edge as the CTRL write, so counters
  // and outputs are already idle in the cycle right after it.
  assign en_d       = ctrl_wr ? sys_wr_data[0] : en_q;
  assign frame_done = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);
  assign out_active = en_q & en_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    if (!en_d) begin
      presc_d       = '0;
      idx_d         = '0;
      phase_d       = '0;
      frame_d       = '0;
      blink_phase_d = 1'b0;
    end else if (en_q) begin
      phase_d = phase_q + 4'd1;
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (blink_period_q == 16'd0) begin
        frame_d       = '0;
        blink_phase_d = 1'b0;
      end else if (frame_done) begin
        if (frame_q + 16'd1 == blink_period_q) begin
          frame_d       = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_d = frame_q + 16'd1;
        end
      end
    end
    if (blink_wr) frame_d = '0;
  end

  always_comb begin
    seg_pat = '0;
    for (int i = 0; i < NDIGITS; i++)
      if (idx_q == 3'(i)) seg_pat = digit_q[i];
  end

  assign seg_d = (out_active && (phase_q <= bright_q) && !(blink_en_q && blink_phase_q))
                 ? seg_pat : 7'h00;
  assign sel_d = out_active ? (NDIGITS'(1) << idx_q) : '0;

  always_comb begin
    rd_mux = '0;
    case (word)
      6'h00:   rd_mux = {20'h0, bright_q, 6'h0, blink_en_q, en_q};
      6'h01:   rd_mux = {16'h0, blink_period_q};
      6'h02:   rd_mux = {23'h0, blink_phase_q, 5'h0, idx_q};
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < NDIGITS; i++)
      if (word == 6'(4 + i)) rd_mux = {25'h0, digit_q[i]};
  end

  assign rd_data_d = rd_stb ? rd_mux : rd_data_q;

  // NOTE: sequential state uses non-blocking assignments only; the digit
  // registers are few, so they are reset along with everything else.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      en_q           <= 1'b0;
      blink_en_q     <= 1'b0;
      bright_q       <= '0;
      blink_period_q <= '0;
      for (int i = 0; i < NDIGITS; i++) digit_q[i] <= '0;
      presc_q        <= '0;
      idx_q          <= '0;
      phase_q        <= '0;
      frame_q        <= '0;
      blink_phase_q  <= 1'b0;
      seg_q          <= '0;
      sel_q          <= '0;
      rd_data_q      <= '0;
    end else begin
      en_q          <= en_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      rd_data_q     <= rd_data_d;
      if (ctrl_wr) begin
        blink_en_q <= sys_wr_data[1];
        bright_q   <= sys_wr_data[11:8];
      end
      if (blink_wr) blink_period_q <= sys_wr_data[15:0];
      for (int i = 0; i < NDIGITS; i++)
        if (wr_stb && (word == 6'(4 + i))) digit_q[i] <= sys_wr_data[6:0];
    end
  end

  // Registers hold active-high values, so reset lands on the inactive level
  // after the polarity inversion for either build.
  assign seg         = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign sel         = SEL_ACTIVE_LOW ? ~sel_q : sel_q;
  assign sys_rd_data = rd_data_q;

endmodule
